// File: rtl/micro_pkg.sv
`default_nettype none
// ============================================================================
// Module  : micro_pkg
// Brief   : Shared widths, flag indices, ALU opcodes and read-forwarding helper
// Revision: 1.0
// ============================================================================
package micro_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int FLAG_W = 3;
  localparam int NREG   = 2 ** ADDR_W;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [FLAG_W-1:0] flags_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_NOT = 3'b100,
    ALU_SHL = 3'b101,
    ALU_SHR = 3'b110,
    ALU_XOR = 3'b111
  } alu_op_e;

  // Immediate load beats ALU writeback, which beats the stored register.
  function automatic data_t fwd_read(
    input addr_t rd_addr,
    input logic  ld_en,
    input addr_t ld_addr,
    input data_t ld_data,
    input logic  wb_en,
    input addr_t wb_addr,
    input data_t wb_data,
    input data_t stored
  );
    if (ld_en && (ld_addr == rd_addr)) begin
      return ld_data;
    end else if (wb_en && (wb_addr == rd_addr)) begin
      return wb_data;
    end
    return stored;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bank_wb_if.sv
`default_nettype none
// ============================================================================
// Module  : reg_bank_wb_if
// Brief   : Control-unit / ALU side bundle of the register bank
// Revision: 1.0
// ============================================================================
interface reg_bank_wb_if;
  import micro_pkg::*;

  addr_t  uc_iSelX;
  addr_t  uc_iSelY;
  data_t  rd_oRX;
  data_t  rd_oRY;
  logic   uc_iWbEn;
  addr_t  uc_iSelW;
  data_t  alu_iRd;
  logic   uc_iFlagEn;
  flags_t alu_iFlags;
  logic   uc_iLdEn;
  addr_t  uc_iSelL;
  data_t  uc_iLdData;
  flags_t oFlags;
  logic   oWrConflict;

  modport master (
    output uc_iSelX, uc_iSelY, uc_iWbEn, uc_iSelW, alu_iRd,
           uc_iFlagEn, alu_iFlags, uc_iLdEn, uc_iSelL, uc_iLdData,
    input  rd_oRX, rd_oRY, oFlags, oWrConflict
  );

  modport slave (
    input  uc_iSelX, uc_iSelY, uc_iWbEn, uc_iSelW, alu_iRd,
           uc_iFlagEn, alu_iFlags, uc_iLdEn, uc_iSelL, uc_iLdData,
    output rd_oRX, rd_oRY, oFlags, oWrConflict
  );

endinterface
`default_nettype wire

// File: rtl/status_reg.sv
`default_nettype none
// ============================================================================
// Module  : status_reg
// Brief   : Enabled register with asynchronous active-low clear (ALU flags)
// Revision: 1.0
// ============================================================================
module status_reg #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule
`default_nettype wire

// File: rtl/reg_bank_wb.sv
`default_nettype none
// ============================================================================
// Module  : reg_bank_wb
// Brief   : 8x8 register bank with load/writeback ports, forwarding and flags
// Revision: 1.0
// ============================================================================
module reg_bank_wb
  import micro_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  reg_bank_wb_if.slave bus
);

  data_t regs_q [NREG];
  data_t regs_d [NREG];
  logic  wr_conflict_q;
  logic  wr_conflict_d;

  // Load is applied after writeback so it wins on an address collision.
  always_comb begin
    regs_d = regs_q;
    if (bus.uc_iWbEn) begin
      regs_d[bus.uc_iSelW] = bus.alu_iRd;
    end
    if (bus.uc_iLdEn) begin
      regs_d[bus.uc_iSelL] = bus.uc_iLdData;
    end
    wr_conflict_d = bus.uc_iLdEn && bus.uc_iWbEn && (bus.uc_iSelL == bus.uc_iSelW);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  // Reads are forced to zero during reset so pending load data cannot leak.
  assign bus.rd_oRX = rst ? fwd_read(bus.uc_iSelX, bus.uc_iLdEn, bus.uc_iSelL, bus.uc_iLdData,
                                     bus.uc_iWbEn, bus.uc_iSelW, bus.alu_iRd,
                                     regs_q[bus.uc_iSelX])
                          : '0;
  assign bus.rd_oRY = rst ? fwd_read(bus.uc_iSelY, bus.uc_iLdEn, bus.uc_iSelL, bus.uc_iLdData,
                                     bus.uc_iWbEn, bus.uc_iSelW, bus.alu_iRd,
                                     regs_q[bus.uc_iSelY])
                          : '0;

  assign bus.oWrConflict = wr_conflict_q;

  status_reg #(
    .WIDTH (FLAG_W)
  ) u_status (
    .clk  (clk),
    .rst  (rst),
    .en_i (bus.uc_iFlagEn),
    .d_i  (bus.alu_iFlags),
    .q_o  (bus.oFlags)
  );

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_wb.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_bank_wb
// Brief   : Directed bench with per-cycle model compare for reg_bank_wb
// Revision: 1.0
// ============================================================================
module tb_reg_bank_wb;
  import micro_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  reg_bank_wb_if bus ();

  reg_bank_wb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain array of register values plus flag/conflict state.
  data_t  m_regs [NREG];
  flags_t m_flags;
  logic   m_conf;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      foreach (m_regs[i]) m_regs[i] <= '0;
      m_flags <= '0;
      m_conf  <= 1'b0;
    end else begin
      if (bus.uc_iWbEn) m_regs[bus.uc_iSelW] <= bus.alu_iRd;
      if (bus.uc_iLdEn) m_regs[bus.uc_iSelL] <= bus.uc_iLdData;
      if (bus.uc_iFlagEn) m_flags <= bus.alu_iFlags;
      m_conf <= bus.uc_iLdEn && bus.uc_iWbEn && (bus.uc_iSelL == bus.uc_iSelW);
    end
  end

  function automatic data_t exp_read(input addr_t a);
    if (!rst) return '0;
    if (bus.uc_iLdEn && bus.uc_iSelL == a) return bus.uc_iLdData;
    if (bus.uc_iWbEn && bus.uc_iSelW == a) return bus.alu_iRd;
    return m_regs[a];
  endfunction

  always @(negedge clk) begin
    chk("cyc_rx",   32'(bus.rd_oRX),      32'(exp_read(bus.uc_iSelX)));
    chk("cyc_ry",   32'(bus.rd_oRY),      32'(exp_read(bus.uc_iSelY)));
    chk("cyc_flag", 32'(bus.oFlags),      32'(m_flags));
    chk("cyc_conf", 32'(bus.oWrConflict), 32'(m_conf));
  end

  // The control unit must never write back to a register being read that cycle.
  always @(negedge clk) begin
    if (rst && bus.uc_iWbEn) begin
      assert (bus.uc_iSelW != bus.uc_iSelX && bus.uc_iSelW != bus.uc_iSelY)
        else $error("writeback destination equals an active read select");
    end
  end

  task automatic alu(input alu_op_e op, input data_t x, input data_t y,
                     output data_t res, output flags_t fl);
    logic [DATA_W:0] wide;
    case (op)
      ALU_ADD: wide = {1'b0, x} + {1'b0, y};
      ALU_SUB: wide = {1'b0, y} - {1'b0, x};
      ALU_AND: wide = {1'b0, x & y};
      ALU_OR:  wide = {1'b0, x | y};
      ALU_XOR: wide = {1'b0, x ^ y};
      default: wide = {1'b0, x};
    endcase
    res         = wide[DATA_W-1:0];
    fl          = '0;
    fl[FLAG_Z]  = (res == '0);
    fl[FLAG_C]  = wide[DATA_W];
    fl[FLAG_N]  = res[DATA_W-1];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.uc_iLdEn   = 1'b0;
    bus.uc_iWbEn   = 1'b0;
    bus.uc_iFlagEn = 1'b0;
  endtask

  data_t  res;
  flags_t fl;

  initial begin
    bus.uc_iSelX   = '0;
    bus.uc_iSelY   = '0;
    bus.uc_iWbEn   = 1'b0;
    bus.uc_iSelW   = '0;
    bus.alu_iRd    = '0;
    bus.uc_iFlagEn = 1'b0;
    bus.alu_iFlags = '0;
    bus.uc_iLdEn   = 1'b1;
    bus.uc_iSelL   = '0;
    bus.uc_iLdData = 8'h55;

    // Reset held with a pending load
    tick();
    tick();
    #1;
    chk("rst_rx",   32'(bus.rd_oRX), 32'h00);
    chk("rst_ry",   32'(bus.rd_oRY), 32'h00);
    chk("rst_flag", 32'(bus.oFlags), 32'h0);
    tick();
    rst = 1'b1;
    idle();
    for (int i = 0; i < NREG; i++) begin
      bus.uc_iSelX = addr_t'(i);
      bus.uc_iSelY = addr_t'(NREG - 1 - i);
      #1;
      chk("post_rst_rx", 32'(bus.rd_oRX), 32'h00);
      chk("post_rst_ry", 32'(bus.rd_oRY), 32'h00);
    end

    // Load and same-cycle forwarding
    tick();
    bus.uc_iLdEn = 1'b1; bus.uc_iSelL = 3'd3; bus.uc_iLdData = 8'hA5;
    bus.uc_iSelX = 3'd3; bus.uc_iSelY = 3'd0;
    #1;
    chk("ld_fwd_x", 32'(bus.rd_oRX), 32'hA5);
    chk("ld_fwd_y", 32'(bus.rd_oRY), 32'h00);
    tick();
    idle();
    bus.uc_iSelX = 3'd3; bus.uc_iSelY = 3'd3;
    #1;
    chk("ld_rd_x", 32'(bus.rd_oRX), 32'hA5);
    chk("ld_rd_y", 32'(bus.rd_oRY), 32'hA5);

    // Dual write, distinct addresses
    tick();
    bus.uc_iLdEn = 1'b1; bus.uc_iSelL = 3'd1; bus.uc_iLdData = 8'h11;
    bus.uc_iWbEn = 1'b1; bus.uc_iSelW = 3'd2; bus.alu_iRd    = 8'h22;
    bus.uc_iSelX = 3'd0; bus.uc_iSelY = 3'd3;
    tick();
    idle();
    bus.uc_iSelX = 3'd1; bus.uc_iSelY = 3'd2;
    #1;
    chk("dual_r1",   32'(bus.rd_oRX),      32'h11);
    chk("dual_r2",   32'(bus.rd_oRY),      32'h22);
    chk("dual_conf", 32'(bus.oWrConflict), 32'h0);

    // Same-address conflict
    tick();
    bus.uc_iLdEn = 1'b1; bus.uc_iSelL = 3'd4; bus.uc_iLdData = 8'h0F;
    bus.uc_iWbEn = 1'b1; bus.uc_iSelW = 3'd4; bus.alu_iRd    = 8'hF0;
    bus.uc_iSelX = 3'd0; bus.uc_iSelY = 3'd1;
    tick();
    idle();
    bus.uc_iSelX = 3'd4;
    #1;
    chk("conf_pulse", 32'(bus.oWrConflict), 32'h1);
    chk("conf_r4",    32'(bus.rd_oRX),      32'h0F);
    tick();
    #1;
    chk("conf_clear", 32'(bus.oWrConflict), 32'h0);

    // Flags: capture, hold, asynchronous clear
    tick();
    bus.uc_iFlagEn = 1'b1; bus.alu_iFlags = 3'b101;
    tick();
    bus.uc_iFlagEn = 1'b0; bus.alu_iFlags = 3'b010;
    #1;
    chk("flag_cap",  32'(bus.oFlags), 32'h5);
    tick();
    #1;
    chk("flag_hold", 32'(bus.oFlags), 32'h5);
    rst = 1'b0;
    #1;
    chk("flag_arst", 32'(bus.oFlags), 32'h0);
    chk("arst_r4",   32'(bus.rd_oRX), 32'h00);
    tick();
    rst = 1'b1;
    #1;
    chk("arst_r4_after", 32'(bus.rd_oRX), 32'h00);

    // ALU loop: R2 = R0 + R1, then R3 = R1 - R2
    tick();
    bus.uc_iLdEn = 1'b1; bus.uc_iSelL = 3'd0; bus.uc_iLdData = 8'h03;
    tick();
    bus.uc_iSelL = 3'd1; bus.uc_iLdData = 8'h05;
    tick();
    idle();
    bus.uc_iSelX = 3'd0; bus.uc_iSelY = 3'd1;
    #1;
    alu(ALU_ADD, bus.rd_oRX, bus.rd_oRY, res, fl);
    bus.alu_iRd = res; bus.alu_iFlags = fl;
    bus.uc_iWbEn = 1'b1; bus.uc_iSelW = 3'd2; bus.uc_iFlagEn = 1'b1;
    tick();
    idle();
    bus.uc_iSelX = 3'd2; bus.uc_iSelY = 3'd1;
    #1;
    chk("add_r2",   32'(bus.rd_oRX), 32'h08);
    chk("add_flag", 32'(bus.oFlags), 32'h0);
    alu(ALU_SUB, bus.rd_oRX, bus.rd_oRY, res, fl);
    bus.alu_iRd = res; bus.alu_iFlags = fl;
    bus.uc_iWbEn = 1'b1; bus.uc_iSelW = 3'd3; bus.uc_iFlagEn = 1'b1;
    tick();
    idle();
    bus.uc_iSelX = 3'd3;
    #1;
    chk("sub_r3",   32'(bus.rd_oRX), 32'hFD);
    chk("sub_flag", 32'(bus.oFlags), 32'h6);

    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_bank_wb.md
Name: reg_bank_wb

Overview:
- Register bank for the 8-bit micro. Sits directly upstream and downstream of the ALU.
- Provides the two combinational read operands that drive the ALU's RX/RY inputs.
- Captures the ALU result and the ALU flags on writeback, and supports an immediate-load write port from the control unit.
- Forwards same-cycle writes to the read ports so back-to-back dependent instructions see fresh data.

Parameters:
- DATA_W, 8, register/data width in bits
- ADDR_W, 3, register address width; the bank holds 2**ADDR_W registers (R0..R7)
- FLAG_W, 3, flag vector width; bit0 = Z, bit1 = C, bit2 = N

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- uc_iSelX  input  ADDR_W  read address for operand X
- uc_iSelY  input  ADDR_W  read address for operand Y
- rd_oRX  output  DATA_W  operand X, drives the ALU RX input
- rd_oRY  output  DATA_W  operand Y, drives the ALU RY input
- uc_iWbEn  input  1  ALU writeback enable
- uc_iSelW  input  ADDR_W  ALU writeback destination
- alu_iRd  input  DATA_W  ALU result
- uc_iFlagEn  input  1  flag capture enable; the control unit asserts it on math operations
- alu_iFlags  input  FLAG_W  ALU flags
- uc_iLdEn  input  1  immediate-load enable
- uc_iSelL  input  ADDR_W  immediate-load destination
- uc_iLdData  input  DATA_W  immediate value
- oFlags  output  FLAG_W  registered status flags
- oWrConflict  output  1  registered; pulses for one cycle after a same-address double write

Behaviour:
- Reset (rst low, asynchronous):
  - All registers cleared to 0; oFlags = 0; oWrConflict = 0.
  - While reset is held, rd_oRX and rd_oRY read 0.
  - Reset wins over any write pending in the same cycle. Deasserting rst mid-sequence leaves every register at 0; no partial write survives.
- Read ports:
  - Combinational, zero latency, from the current register contents.
  - Forwarding priority for a read: (1) if uc_iLdEn and uc_iSelL equals the read address, return uc_iLdData; (2) else if uc_iWbEn and uc_iSelW equals the read address, return alu_iRd; (3) else return the stored register.
  - Forwarding applies to X and Y independently.
  - No combinational loop is allowed: alu_iRd must not be forwarded when the ALU consumes rd_oRX/rd_oRY in the same cycle. The control unit never asserts uc_iWbEn with uc_iSelW equal to an active read select in the same cycle. An assertion in the bench checks this; the RTL forwards regardless.
- Writes (rising edge):
  - uc_iLdEn writes uc_iLdData to R[uc_iSelL].
  - uc_iWbEn writes alu_iRd to R[uc_iSelW].
  - Both enabled with different addresses: both writes occur in the same cycle.
  - Both enabled with the same address: the load wins, and oWrConflict = 1 on the next cycle only.
  - Neither enabled: all registers hold.
- Flags (rising edge):
  - If uc_iFlagEn, oFlags <= alu_iFlags; otherwise hold.
  - Flags update independently of uc_iWbEn, so compare-style ops can set flags without writing back.
  - Flag latency is 1 cycle.
- Width: no arithmetic in this block; data passes bit-exact. Register R0 is general purpose, not hardwired.
- No X propagation: out-of-range addresses are impossible because the bank holds exactly 2**ADDR_W registers.

Decomposition:
- Shared package `micro_pkg`:
  - DATA_W, ADDR_W, FLAG_W.
  - Flag indices FLAG_Z=0, FLAG_C=1, FLAG_N=2.
  - ALU opcode constants (ADD=000 … XOR=111), which the ALU also adopts.
- One sub-module: `status_reg`, an FLAG_W-bit enable register with asynchronous active-low clear, instanced for oFlags.
- Bank storage and forwarding muxes stay in the top level.

Test Plan:
- Reset: hold rst=0 with uc_iLdEn=1, Data=0x55 → all reads 0 and oFlags=000. Release, read R0..R7 → all 0x00.
- Load/read: load R3=0xA5. Next cycle SelX=3, SelY=3 → rd_oRX=rd_oRY=0xA5. Same cycle as the load, SelX=3 → 0xA5 via forwarding.
- Dual write: Ld R1=0x11 and Wb R2=0x22 in the same cycle → next cycle R1=0x11, R2=0x22, oWrConflict=0.
- Conflict: Ld R4=0x0F and Wb R4=0xF0 → R4=0x0F and oWrConflict=1 for exactly one cycle, then 0.
- Flags: FlagEn=1, alu_iFlags=101 → oFlags=101 next cycle. FlagEn=0, alu_iFlags=010 → oFlags stays 101. Async reset mid-run → oFlags=000 immediately.
- ALU loop: R0=0x03, R1=0x05 with ALU ADD (bench model), Wb to R2 → R2=0x08. Then R2 as X with R1 as Y, SUB → R1−R2 = 0xFD, N flag captured.
